// File: rtl/label_overlay_renderer.sv
// VGA text-label overlay: N_LABELS glyph-ROM labels in one row, 3-edge DrawX->RGB pipeline.
// Define LABEL_CURSOR_EN to build the blinking cursor highlight and sel_next/frame_start handling.
module label_overlay_renderer #(
   parameter int N_LABELS     = 4,
   parameter int LABEL_W      = 120,
   parameter int LABEL_H      = 13,
   parameter int X_START      = 20,
   parameter int X_PITCH      = 150,
   parameter int ROW_Y        = 240,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                                            Clk,
   input  logic                                            reset,
   input  logic                                            frame_start,
   input  logic [9:0]                                      DrawX,
   input  logic [9:0]                                      DrawY,
   input  logic [N_LABELS-1:0]                             active,
   input  logic                                            sel_next,
   output logic [$clog2(N_LABELS)+$clog2(LABEL_H)-1:0]     rom_addr,
   input  logic [LABEL_W-1:0]                              rom_data,
   output logic [$clog2(N_LABELS)-1:0]                     sel_index,
   output logic [7:0]                                      VGA_R,
   output logic [7:0]                                      VGA_G,
   output logic [7:0]                                      VGA_B
);
   localparam int IW = $clog2(N_LABELS);
   localparam int RW = $clog2(LABEL_H);
   localparam int CW = $clog2(LABEL_W);

   int dx, dy;
   assign dx = int'(DrawX);
   assign dy = int'(DrawY);

   logic          hit_d;
   logic [IW-1:0] idx_d;
   logic [CW-1:0] col_d;
   logic [RW-1:0] row_d;

   always_comb begin
      hit_d = 1'b0;
      idx_d = '0;
      col_d = '0;
      row_d = RW'(dy - ROW_Y);
      if (dy >= ROW_Y && dy < ROW_Y + LABEL_H) begin
         for (int i = 0; i < N_LABELS; i++) begin
            if (dx >= X_START + i*X_PITCH && dx < X_START + i*X_PITCH + LABEL_W) begin
               hit_d = 1'b1;
               idx_d = IW'(i);
               col_d = CW'(dx - X_START - i*X_PITCH);
            end
         end
      end
   end

   logic [IW+RW-1:0] rom_addr_q;
   logic             hit0_q, hit1_q, pix1_q, act1_q;
   logic [IW-1:0]    idx0_q, idx1_q;
   logic [CW-1:0]    col0_q, pix_sel;
   logic [23:0]      rgb_q, rgb_d;
   logic             cursor_hl;

   // Leftmost pixel is the ROM word's MSB.
   assign pix_sel = CW'(LABEL_W-1) - col0_q;

   always_ff @(posedge Clk) begin
      if (reset) begin
         rom_addr_q <= '0;
         hit0_q     <= 1'b0;
         idx0_q     <= '0;
         col0_q     <= '0;
         hit1_q     <= 1'b0;
         pix1_q     <= 1'b0;
         idx1_q     <= '0;
         act1_q     <= 1'b0;
         rgb_q      <= '0;
      end else begin
         hit0_q <= hit_d;
         if (hit_d) begin
            rom_addr_q <= {idx_d, row_d};
            idx0_q     <= idx_d;
            col0_q     <= col_d;
         end
         hit1_q <= hit0_q;
         pix1_q <= rom_data[pix_sel];
         idx1_q <= idx0_q;
         act1_q <= active[idx0_q];
         rgb_q  <= rgb_d;
      end
   end

   always_comb begin
      rgb_d = 24'h000000;
      if (hit1_q) begin
         if (pix1_q && act1_q)  rgb_d = 24'h00FF00;
         else if (pix1_q)       rgb_d = 24'hFFFFFF;
         else if (cursor_hl)    rgb_d = 24'h404000;
      end
   end

`ifdef LABEL_CURSOR_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   logic [IW-1:0] sel_q, sel_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;

   always_comb begin
      sel_d         = sel_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (sel_next)
         sel_d = (sel_q == IW'(N_LABELS-1)) ? '0 : sel_q + 1'b1;
      if (frame_start) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES-1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         sel_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         sel_q         <= sel_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign cursor_hl = blink_phase_q && (idx1_q == sel_q);
   assign sel_index = sel_q;
`else
   logic unused_cursor_inputs;
   assign unused_cursor_inputs = ^{sel_next, frame_start};
   assign cursor_hl = 1'b0;
   assign sel_index = '0;
`endif

   assign rom_addr = rom_addr_q;
   assign VGA_R    = rgb_q[23:16];
   assign VGA_G    = rgb_q[15:8];
   assign VGA_B    = rgb_q[7:0];
endmodule

// File: tb/tb_label_overlay_renderer.sv
// Directed bench for label_overlay_renderer: hit region, ROM bit order, latency, cursor/blink, reset.
module tb_label_overlay_renderer;
   logic         Clk = 1'b0;
   logic         reset, frame_start, sel_next;
   logic [9:0]   DrawX, DrawY;
   logic [3:0]   active;
   logic [119:0] rom_data;
   logic [5:0]   rom_addr;
   logic [1:0]   sel_index;
   logic [7:0]   VGA_R, VGA_G, VGA_B;
   logic [23:0]  rgb;
   int           n_chk = 0;
   int           n_fail = 0;

`ifdef LABEL_CURSOR_EN
   localparam bit CUR = 1'b1;
`else
   localparam bit CUR = 1'b0;
`endif

   always #5 Clk = ~Clk;
   assign rgb = {VGA_R, VGA_G, VGA_B};

   label_overlay_renderer #(.BLINK_FRAMES(2)) dut (
      .Clk(Clk), .reset(reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .active(active), .sel_next(sel_next), .rom_addr(rom_addr), .rom_data(rom_data),
      .sel_index(sel_index), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // Present one pixel and wait the full 3-edge pipeline.
   task automatic px(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      step(3);
   endtask

   task automatic pulse(input bit fs, input bit sn);
      frame_start = fs;
      sel_next    = sn;
      step(1);
      frame_start = 1'b0;
      sel_next    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; frame_start = 1'b0; sel_next = 1'b0;
      DrawX = 10'd20; DrawY = 10'd240; active = 4'b0001; rom_data = '1;
      @(posedge Clk); #1;
      for (int k = 0; k < 5; k++) begin
         DrawX = 10'(20 + k*150);
         step(1);
         check("rst_rgb", 32'(rgb), 32'h0);
         check("rst_addr", 32'(rom_addr), 32'h0);
         check("rst_sel", 32'(sel_index), 32'h0);
      end

      // Latency and label-column boundaries
      reset = 1'b0; DrawX = 10'd20; DrawY = 10'd240;
      step(2); check("lat_2edge_black", 32'(rgb), 32'h0);
      step(1); check("l0_green", 32'(rgb), 32'h00FF00);
      px(170, 240); check("l1_white", 32'(rgb), 32'hFFFFFF); check("l1_addr", 32'(rom_addr), 32'h10);
      px(140, 240); check("x140_black", 32'(rgb), 32'h0); check("addr_hold", 32'(rom_addr), 32'h10);
      px(139, 240); check("x139_green", 32'(rgb), 32'h00FF00);
      px(169, 240); check("x169_black", 32'(rgb), 32'h0);
      px(320, 240); check("l2_white", 32'(rgb), 32'hFFFFFF); check("l2_addr", 32'(rom_addr), 32'h20);
      active = 4'b1001;
      px(470, 240); check("l3_green", 32'(rgb), 32'h00FF00); check("l3_addr", 32'(rom_addr), 32'h30);
      active = 4'b0001;

      // Row boundaries and ROM bit order
      px(20, 252); check("row12_addr", 32'(rom_addr), 32'd12); check("row12_green", 32'(rgb), 32'h00FF00);
      px(20, 253); check("y253_black", 32'(rgb), 32'h0); check("y253_addr_hold", 32'(rom_addr), 32'd12);
      px(20, 239); check("y239_black", 32'(rgb), 32'h0);
      rom_data = '0; rom_data[119] = 1'b1;
      px(20, 240);  check("msb_x20", 32'(rgb), 32'h00FF00);
      px(21, 240);  check("msb_x21", 32'(rgb), 32'h0);
      rom_data = '0; rom_data[0] = 1'b1;
      px(139, 240); check("lsb_x139", 32'(rgb), 32'h00FF00);
      px(138, 240); check("lsb_x138", 32'(rgb), 32'h0);
      rom_data = '1;
      px(700, 500); check("blank_black", 32'(rgb), 32'h0);

      // Cursor advance with wrap
      for (int k = 0; k < 5; k++) begin
         pulse(1'b0, 1'b1);
         check("sel_adv", 32'(sel_index), CUR ? 32'((k + 1) % 4) : 32'h0);
      end

      // Blink with BLINK_FRAMES=2; no frame_start yet since reset
      rom_data = '0; active = 4'b0000;
      px(200, 240); check("f0_l1", 32'(rgb), 32'h0);
      pulse(1'b1, 1'b0);
      px(200, 240); check("f1_l1", 32'(rgb), 32'h0);
      pulse(1'b1, 1'b1);
      check("f2_sel", 32'(sel_index), CUR ? 32'd2 : 32'd0);
      px(350, 240); check("f2_l2_hl", 32'(rgb), CUR ? 32'h404000 : 32'h0);
      px(200, 240); check("f2_l1", 32'(rgb), 32'h0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      px(500, 240); check("f3_l3_hl", 32'(rgb), CUR ? 32'h404000 : 32'h0);
      px(350, 240); check("f3_l2", 32'(rgb), 32'h0);
      rom_data = '1;
      px(500, 240); check("f3_pix_wins", 32'(rgb), 32'hFFFFFF);
      rom_data = '0;
      pulse(1'b1, 1'b0);
      px(500, 240); check("f4_l3", 32'(rgb), 32'h0);

      // Reset mid-label
      rom_data = '1; active = 4'b0001;
      px(20, 240); check("pre_rst_green", 32'(rgb), 32'h00FF00);
      reset = 1'b1;
      step(1);
      check("midrst_rgb", 32'(rgb), 32'h0);
      check("midrst_sel", 32'(sel_index), 32'h0);
      check("midrst_addr", 32'(rom_addr), 32'h0);
      reset = 1'b0;
      step(3); check("refill_green", 32'(rgb), 32'h00FF00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
